// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-serialising RAM arbiter.
// State, owner and access-size encodings plus the size-code decoder.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_READ  = 2'd1,
    ARB_WRITE = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  // Size code 3 is treated as a full word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: len_bytes = 3'd1;
      LEN_HALF: len_bytes = 3'd2;
      default:  len_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one byte-wide synchronous RAM between instruction fetch and the
// data port; each request becomes 1/2/4 serial byte accesses and a done pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  arb_state_t        state_reg, state_next;
  owner_t            owner_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [2:0]        nbytes_reg;
  logic [2:0]        cnt_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       data_reg;
  logic [RAM_AW-1:0] ram_addr_reg;
  logic              ram_wr_reg;
  logic [7:0]        ram_dout_reg;

  logic [ADDR_W-1:0] byte_addr;
  logic [31:0]       shifted;
  logic [5:0]        align_shift;
  logic              last_capture;
  logic              unused_addr_hi;

  // Wrap at the full requester width, then keep only the RAM address bits.
  assign byte_addr      = base_reg + ADDR_W'(cnt_reg);
  assign unused_addr_hi = ^byte_addr[ADDR_W-1:RAM_AW];

  // Bytes shift in from the top; a short access is right-aligned at the end.
  assign shifted      = {ram_din, data_reg[31:8]};
  assign align_shift  = {3'd4 - nbytes_reg, 3'b000};
  assign last_capture = (cnt_reg == nbytes_reg + 3'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ARB_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (mem_req)     state_next = mem_we ? ARB_WRITE : ARB_READ;
        else if (if_req) state_next = ARB_READ;
      end
      ARB_READ:  if (last_capture) state_next = ARB_DONE;
      ARB_WRITE: if (cnt_reg == nbytes_reg) state_next = ARB_DONE;
      default:   state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_reg    <= OWN_FETCH;
      base_reg     <= '0;
      nbytes_reg   <= '0;
      cnt_reg      <= '0;
      wdata_reg    <= '0;
      data_reg     <= '0;
      ram_addr_reg <= '0;
      ram_wr_reg   <= 1'b0;
      ram_dout_reg <= '0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          ram_wr_reg <= 1'b0;
          cnt_reg    <= '0;
          if (mem_req) begin
            owner_reg  <= OWN_DATA;
            base_reg   <= mem_addr;
            nbytes_reg <= len_bytes(mem_len);
            wdata_reg  <= mem_wdata;
            data_reg   <= '0;
          end else if (if_req) begin
            owner_reg  <= OWN_FETCH;
            base_reg   <= if_addr;
            nbytes_reg <= 3'd4;
            data_reg   <= '0;
          end
        end
        ARB_READ: begin
          ram_wr_reg <= 1'b0;
          cnt_reg    <= cnt_reg + 3'd1;
          if (cnt_reg < nbytes_reg) ram_addr_reg <= byte_addr[RAM_AW-1:0];
          // The byte addressed two cycles earlier is on ram_din now.
          if (cnt_reg >= 3'd2) data_reg <= last_capture ? (shifted >> align_shift) : shifted;
        end
        ARB_WRITE: begin
          cnt_reg <= cnt_reg + 3'd1;
          if (cnt_reg < nbytes_reg) begin
            ram_wr_reg   <= 1'b1;
            ram_addr_reg <= byte_addr[RAM_AW-1:0];
            ram_dout_reg <= wdata_reg[7:0];
            wdata_reg    <= wdata_reg >> 8;
          end else begin
            ram_wr_reg <= 1'b0;
          end
        end
        default: ram_wr_reg <= 1'b0;
      endcase
    end
  end

  assign ram_addr  = ram_addr_reg;
  assign ram_wr    = ram_wr_reg;
  assign ram_dout  = ram_dout_reg;
  assign if_data   = data_reg;
  assign mem_rdata = data_reg;
  assign if_done   = (state_reg == ARB_DONE) && (owner_reg == OWN_FETCH);
  assign mem_done  = (state_reg == ARB_DONE) && (owner_reg == OWN_DATA);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded random/directed bench: a byte-array RAM model, a reference
// memory image and a queue of expected completions checked by a monitor.
module tb_mem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int RAM_AW   = 17;
  localparam int RAM_SIZE = 1 << RAM_AW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic [31:0]       if_data;
  logic              if_done;
  logic              mem_req = 1'b0;
  logic              mem_we = 1'b0;
  logic [1:0]        mem_len = 2'd0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [31:0]       mem_wdata = '0;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .RAM_AW(RAM_AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  logic [7:0] ram     [RAM_SIZE];
  logic [7:0] ref_mem [RAM_SIZE];

  always @(posedge clk) begin
    if (ram_wr) ram[ram_addr] <= ram_dout;
    ram_din <= ram[ram_addr];
  end

  int cyc = 0;
  int wr_cycles = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ram_wr) wr_cycles++;

  typedef struct {
    bit          own_mem;
    bit          chk_data;
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int nb(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  function automatic int ra(input logic [31:0] a, input int i);
    logic [31:0] s;
    s = a + 32'(i);
    return int'(s[RAM_AW-1:0]);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[ra(a, i)];
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] wd);
    for (int i = 0; i < n; i++) ref_mem[ra(a, i)] = wd[8*i +: 8];
  endtask

  // Read completes N+2 cycles after the grant edge, write N+1.
  task automatic expect_txn(input bit own_mem, input bit we, input logic [1:0] len,
                            input logic [31:0] a, input logic [31:0] wd, input int grant,
                            input string name, output int done_cyc);
    exp_t e;
    int n;
    n = own_mem ? nb(len) : 4;
    e.own_mem  = own_mem;
    e.name     = name;
    e.chk_data = !we;
    if (we) begin
      ref_store(a, n, wd);
      e.data = '0;
    end else begin
      e.data = ref_load(a, n);
    end
    e.cyc    = grant + (we ? n + 1 : n + 2);
    done_cyc = e.cyc;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && (if_done || mem_done)) begin
      check("done_exclusive", {31'b0, if_done & mem_done}, 32'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: if_done=%b mem_done=%b, expected none", if_done, mem_done);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_owner"}, {31'b0, mem_done}, {31'b0, mon_e.own_mem});
        check({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.cyc));
        if (mon_e.chk_data)
          check({mon_e.name, "_data"}, mem_done ? mem_rdata : if_data, mon_e.data);
        $display("txn %s owner=%s data=%h cycle=%0d", mon_e.name,
                 mem_done ? "mem" : "fetch", mem_done ? mem_rdata : if_data, cyc);
      end
    end
  end

  task automatic run(input bit do_mem, input bit do_fetch, input bit we, input logic [1:0] len,
                     input logic [31:0] maddr, input logic [31:0] wdata, input logic [31:0] faddr,
                     input bit scramble, input bit drop_early, input string name);
    int g, dc, w0;
    bit ok;
    @(negedge clk);
    g  = cyc + 1;
    w0 = wr_cycles;
    dc = 0;
    if (do_mem) begin
      expect_txn(1'b1, we, len, maddr, wdata, g, {name, "_mem"}, dc);
      g = dc + 2;  // done cycle, then one IDLE cycle before the waiting fetch is granted
    end
    if (do_fetch) expect_txn(1'b0, 1'b0, 2'd2, faddr, 32'd0, g, {name, "_if"}, dc);
    mem_req = do_mem; mem_we = we; mem_len = len; mem_addr = maddr; mem_wdata = wdata;
    if_req = do_fetch; if_addr = faddr;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0 && scramble) begin
        if (do_mem) begin
          mem_addr = $urandom; mem_wdata = $urandom; mem_len = 2'($urandom_range(0, 3));
        end else begin
          if_addr = $urandom;
        end
      end
      if (k == 1 && drop_early) mem_req = 1'b0;
      #1;
      if (if_done) if_req = 1'b0;
      if (mem_done) mem_req = 1'b0;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: %0d completions pending, expected 0", name, sb.size());
      sb.delete();
      if_req = 1'b0;
      mem_req = 1'b0;
    end
    check({name, "_wr_cycles"}, 32'(wr_cycles - w0), 32'((do_mem && we) ? nb(len) : 0));
  endtask

  task automatic set_byte(input int a, input logic [7:0] v);
    ram[a] = v;
    ref_mem[a] = v;
  endtask

  initial begin
    logic [7:0] v;
    logic [31:0] rd;
    int c, m;
    bit r_mem, r_if, r_we;
    int kind;

    for (int i = 0; i < RAM_SIZE; i++) begin
      v = 8'($urandom);
      ram[i] = v;
      ref_mem[i] = v;
    end
    set_byte(32'h100, 8'h13); set_byte(32'h101, 8'h05);
    set_byte(32'h102, 8'h00); set_byte(32'h103, 8'h00);

    #2 rst = 1'b0;
    #1;
    check("rst_ram_wr", {31'b0, ram_wr}, 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_dout", 32'(ram_dout), 32'd0);
    check("rst_dones", {30'b0, if_done, mem_done}, 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run(1'b0, 1'b1, 1'b0, 2'd2, 32'd0, 32'd0, 32'h100, 1'b0, 1'b0, "fetch_100");

    run(1'b1, 1'b0, 1'b1, 2'd2, 32'h20, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, "sw_20");
    check("sw_b0", 32'(ram[32'h20]), 32'hEF);
    check("sw_b1", 32'(ram[32'h21]), 32'hBE);
    check("sw_b2", 32'(ram[32'h22]), 32'hAD);
    check("sw_b3", 32'(ram[32'h23]), 32'hDE);
    run(1'b1, 1'b0, 1'b0, 2'd0, 32'h22, 32'd0, 32'd0, 1'b0, 1'b0, "lb_22");

    run(1'b1, 1'b1, 1'b0, 2'd1, 32'h40, 32'd0, 32'h100, 1'b0, 1'b0, "contend");

    run(1'b1, 1'b0, 1'b0, 2'd2, 32'h0001FFFF, 32'd0, 32'd0, 1'b0, 1'b0, "wrap_ram");
    run(1'b1, 1'b0, 1'b0, 2'd3, 32'hFFFFFFFE, 32'd0, 32'd0, 1'b0, 1'b0, "wrap_addr");
    run(1'b1, 1'b0, 1'b1, 2'd2, 32'h0001FFFE, 32'h11223344, 32'd0, 1'b0, 1'b0, "wrap_st");

    // Abort a word store after its second byte has been written.
    @(negedge clk);
    c = cyc;
    rd = 32'hCAFEF00D;
    ref_store(32'h300, 2, rd);
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h300; mem_wdata = rd;
    while (cyc < c + 4) @(negedge clk);
    rst = 1'b0;
    mem_req = 1'b0;
    #1;
    check("abort_ram_wr", {31'b0, ram_wr}, 32'd0);
    check("abort_mem_done", {31'b0, mem_done}, 32'd0);
    check("abort_ram_addr", 32'(ram_addr), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) check("abort_ram_byte", 32'(ram[32'h300 + i]), 32'(ref_mem[32'h300 + i]));
    run(1'b0, 1'b1, 1'b0, 2'd2, 32'd0, 32'd0, 32'h100, 1'b0, 1'b0, "fetch_after_rst");

    run(1'b1, 1'b0, 1'b0, 2'd2, 32'h24, 32'd0, 32'd0, 1'b1, 1'b1, "drop_lw");
    run(1'b0, 1'b1, 1'b0, 2'd2, 32'd0, 32'd0, 32'h22, 1'b0, 1'b0, "fetch_after_drop");

    for (int t = 0; t < 60; t++) begin
      kind  = $urandom_range(0, 2);
      r_mem = (kind != 0);
      r_if  = (kind != 1);
      r_we  = 1'($urandom);
      run(r_mem, r_if, r_we, 2'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0) ? (32'h0001FFFC + 32'($urandom_range(0, 3))) : $urandom,
          $urandom, $urandom, 1'b1, r_mem && ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", t));
    end

    m = 0;
    for (int i = 0; i < RAM_SIZE; i++) if (ram[i] !== ref_mem[i]) m++;
    check("ram_image", 32'(m), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide synchronous RAM between instruction fetch (driven by the PC stage) and the MEM stage's load/store port.
- Serialises each request into byte accesses, assembles or disassembles 32-bit little-endian words, and returns a one-cycle done pulse.
- The pipeline controller derives pc_stall from if_req && !if_done.
- Data port has priority over fetch.

Parameters:
- ADDR_W, 32, requester address width.
- RAM_AW, 17, RAM address width; ram_addr = low RAM_AW bits of the byte address.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request (level, held until if_done).
- if_addr  in  ADDR_W  fetch byte address.
- if_data  out  32  fetched word, valid while if_done=1.
- if_done  out  1  one-cycle completion pulse for fetch.
- mem_req  in  1  data request (level).
- mem_we  in  1  1 = store, 0 = load.
- mem_len  in  2  access size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is treated as 4.
- mem_addr  in  ADDR_W  data byte address.
- mem_wdata  in  32  store data; byte i is taken from bits [8i+7:8i].
- mem_rdata  out  32  load data, zero-extended; valid while mem_done=1.
- mem_done  out  1  one-cycle completion pulse for data.
- ram_addr  out  RAM_AW  RAM byte address.
- ram_wr  out  1  RAM write enable.
- ram_dout  out  8  RAM write data.
- ram_din  in  8  RAM read data; valid one cycle after ram_addr is presented.

Behaviour:
- Reset (rst=0, asynchronous) clears all of the following immediately:
  - state goes to IDLE;
  - ram_wr=0, ram_addr=0, ram_dout=0;
  - if_done=0, mem_done=0;
  - if_data=0, mem_rdata=0;
  - byte counter cleared.
  - Reset mid-transaction aborts it: no done pulse, and no further RAM write is issued.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - Sample requests each rising edge.
  - mem_req wins over if_req.
  - On grant, latch owner, base address, length N (1/2/4), we and wdata; counter=0.
  - Go to READ (fetch, or load) or WRITE (store).
- READ (one byte per cycle, one-cycle RAM latency):
  - ram_addr = base+cnt for cnt = 0..N-1 on consecutive cycles.
  - Byte returned on ram_din one cycle later goes to data[8i+7:8i].
  - After byte N-1 is captured, go to DONE.
  - done rises exactly N+2 cycles after the granting edge: fetch = 6 cycles, LB = 3 cycles.
- WRITE:
  - ram_wr=1 with ram_addr=base+cnt and ram_dout=wdata byte cnt, for N consecutive cycles.
  - Then go to DONE with ram_wr=0.
  - done rises N+1 cycles after the granting edge.
- DONE:
  - Owner's done=1 for exactly one cycle; data output holds the assembled word; unused upper bytes are 0.
  - Return to IDLE.
  - The done cycle never grants, so requesters must drop or refresh req on the edge that samples done.
  - A req still high in IDLE is a new request.
- Address arithmetic: base+cnt computed at ADDR_W bits, wrapping modulo 2^ADDR_W, then truncated to RAM_AW.
- Requester inputs are latched at grant:
  - later changes to addr, data or len have no effect;
  - dropping req mid-transaction does not abort it (stores must not tear), and done still pulses.
- Simultaneous if_req and mem_req in IDLE: data is served first. Fetch is served on the next IDLE if still requested; the fetch stall lasts the full data transaction plus fetch.
- No starvation guard; MEM-stage requests are bounded by the pipeline.
- ram_wr is never high outside WRITE.
- if_done and mem_done are never high in the same cycle.

Decomposition:
- Shared constants go in defines.v:
  - state encodings (`ArbIdle/`ArbRead/`ArbWrite/`ArbDone);
  - mem_len codes (`LenByte=2'b00, `LenHalf=2'b01, `LenWord=2'b10);
  - `RamAddrBus.
- No sub-module; byte assembly is a shifted register within the block.

Test Plan:
- Fetch: RAM[0x100..0x103]=13,05,00,00; if_req=1, if_addr=0x100 -> if_done on the 6th cycle after grant, if_data=0x00000513, ram_wr stays 0.
- Store then load: mem_we=1, len=2, mem_addr=0x20, wdata=0xDEADBEEF -> RAM[0x20..0x23]=EF,BE,AD,DE, mem_done 5 cycles after grant. Then len=0 load at 0x22 -> mem_rdata=0x000000AD after 3 cycles.
- Contention: if_req and mem_req (LH at 0x40) both rise in the same cycle -> mem_done first, if_done later, never overlapping; fetch data is correct.
- Wrap: len=2 load at ram address 0x1FFFF (RAM_AW=17) -> bytes read from 0x1FFFF, 0x0, 0x1, 0x2.
- Reset mid-store: rst=0 after 2 of 4 store bytes -> ram_wr falls immediately, only 2 bytes changed, no mem_done. After release, the next fetch works.
- Requester drops mem_req mid-load -> mem_done still pulses once; arbiter back in IDLE the following cycle.
